// File: rtl/ram_test_sequencer_if.sv
// Request/done bus between the RAM self-test sequencer
// and a single-port RAM controller.
interface ram_test_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_done
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_done
  );
endinterface

// File: rtl/ram_test_sequencer.sv
// Dual-bank SRAM self-test: write, verify, copy with -1
// transform into bank 1, verify again; counts mismatches.
module ram_test_sequencer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int BURST_LEN = 10,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  ram_test_sequencer_if.master ram,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [CNT_W-1:0]  err_count,
  output logic [2:0]        state_code,
  output logic [15:0]       ledout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_RD0  = 3'd2,
    S_CPR  = 3'd3,
    S_CPW  = 3'd4,
    S_RD1  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [DATA_W-1:0] D_ONE = 1;
  localparam logic [CNT_W-1:0]  C_ONE = 1;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [DATA_W-1:0] r_seed, w_seed;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [DATA_W-1:0] r_latch, w_latch;
  logic [7:0]        r_rd, w_rd;
  logic [ADDR_W:0]   r_addr, w_addr;
  logic [CNT_W-1:0]  r_err, w_err;
  logic [15:0]       r_led, w_led;
  logic              r_req, w_req;
  logic              r_we, w_we;
  logic              r_mis, w_mis;

  logic              w_done;
  logic              w_last;
  logic              w_go;
  logic              w_issue;
  logic              w_ok;
  logic [DATA_W-1:0] w_dat;

  assign w_done = r_req & ram.mem_done;
  assign w_last = (r_idx == LAST);
  assign w_dat  = r_seed + DATA_W'(r_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_seed  <= '0;
      r_wdata <= '0;
      r_latch <= '0;
      r_rd    <= '0;
      r_addr  <= '0;
      r_err   <= '0;
      r_led   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_seed  <= w_seed;
      r_wdata <= w_wdata;
      r_latch <= w_latch;
      r_rd    <= w_rd;
      r_addr  <= w_addr;
      r_err   <= w_err;
      r_led   <= w_led;
      r_req   <= w_req;
      r_we    <= w_we;
      r_mis   <= w_mis;
    end
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_seed  = r_seed;
    w_wdata = r_wdata;
    w_latch = r_latch;
    w_rd    = r_rd;
    w_addr  = r_addr;
    w_req   = r_req;
    w_we    = r_we;
    w_mis   = 1'b0;
    w_go    = 1'b0;
    w_issue = 1'b0;
    w_ok    = 1'b0;
    w_led   = r_led;
    // a mismatch seen on the previous done lands here
    w_err   = (r_mis && r_err != '1) ? r_err + C_ONE : r_err;

    unique case (r_state)
      S_IDLE, S_DONE: w_go = start;
      S_WR0: if (w_done) begin
        w_req = 1'b0;
        if (w_last) begin
          w_state = S_RD0;
          w_idx   = '0;
        end else begin
          w_idx = r_idx + A_ONE;
        end
      end
      S_RD0: if (w_done) begin
        w_req = 1'b0;
        w_rd  = ram.mem_rdata[7:0];
        w_mis = (ram.mem_rdata != w_dat);
        if (w_last) begin
          w_state = S_CPR;
          w_idx   = LAST;
        end else begin
          w_idx = r_idx + A_ONE;
        end
      end
      S_CPR: if (w_done) begin
        w_req   = 1'b0;
        w_latch = ram.mem_rdata;
        w_rd    = ram.mem_rdata[7:0];
        w_state = S_CPW;
      end
      S_CPW: if (w_done) begin
        w_req = 1'b0;
        if (r_idx == '0) begin
          w_state = S_RD1;
        end else begin
          w_state = S_CPR;
          w_idx   = r_idx - A_ONE;
        end
      end
      S_RD1: if (w_done) begin
        w_req = 1'b0;
        w_rd  = ram.mem_rdata[7:0];
        w_mis = (ram.mem_rdata != (w_dat - D_ONE));
        if (w_last) begin
          w_state = S_DONE;
        end else begin
          w_idx = r_idx + A_ONE;
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (r_state inside {S_WR0, S_RD0, S_CPR, S_CPW, S_RD1})
      w_issue = !r_req;

    if (w_go) begin
      w_state = S_WR0;
      w_idx   = '0;
      w_seed  = seed;
      w_err   = '0;
      w_mis   = 1'b0;
      w_issue = 1'b1;
    end

    if (w_issue) begin
      w_req   = 1'b1;
      w_we    = (w_state == S_WR0) || (w_state == S_CPW);
      w_addr  = {(w_state == S_CPW) || (w_state == S_RD1),
                 ADDR_W'(w_seed) + w_idx};
      w_wdata = '0;
      unique case (1'b1)
        w_state == S_WR0: w_wdata = w_seed + DATA_W'(w_idx);
        w_state == S_CPW: w_wdata = r_latch - D_ONE;
        default: ;
      endcase
    end

    w_ok = (w_err == '0) && !w_mis;
    unique case (w_state)
      S_IDLE:  w_led = {8'h00, seed[7:0]};
      S_DONE:  w_led = {w_ok ? 8'hD0 : 8'hFA, 8'(w_err)};
      default: w_led = {w_addr[7:0], w_we ? w_wdata[7:0] : w_rd};
    endcase

    if (!en) begin
      w_state = S_IDLE;
      w_idx   = '0;
      w_seed  = '0;
      w_wdata = '0;
      w_latch = '0;
      w_rd    = '0;
      w_addr  = '0;
      w_err   = '0;
      w_led   = '0;
      w_req   = 1'b0;
      w_we    = 1'b0;
      w_mis   = 1'b0;
    end
  end

  assign ram.mem_req   = r_req;
  assign ram.mem_we    = r_we;
  assign ram.mem_addr  = r_addr;
  assign ram.mem_wdata = r_wdata;

  // the pending mismatch gates pass so DONE never flashes a false pass
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign pass       = (r_state == S_DONE) && (r_err == '0) && !r_mis;
  assign fail       = (r_state == S_DONE) && !((r_err == '0) && !r_mis);
  assign err_count  = r_err;
  assign state_code = r_state;
  assign ledout     = r_led;

endmodule
